// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the BRAM port arbiter: response-owner encoding,
// the "no write" byte-enable value and the default starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2
    } resp_own_t;

    localparam logic [3:0] MEM_WE_NONE          = 4'b0000;
    localparam int         STARVE_LIMIT_DEFAULT = 4;
    localparam int         STARVE_W             = 4;

    // A read is any DM access that enables no byte lanes.
    function automatic logic is_read(input logic [3:0] we);
        return (we == MEM_WE_NONE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, DM requester and BRAM port signals around the arbiter,
// plus read-only debug taps of the arbiter state.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    // Handshake: a requester raises req with its address (and write data/enables)
    // and holds all of them stable until gnt is seen high in the same cycle; gnt is
    // combinational from req. A granted read returns rvalid with rdata exactly one
    // cycle later; writes return nothing. Nothing is queued by the arbiter.
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic [DATA_W-1:0] dm_addr;
    logic [3:0]        dm_we;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic [DATA_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    resp_own_t         dbg_resp_own;
    logic [STARVE_W-1:0] dbg_starve_cnt;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_addr, dm_we, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output dbg_resp_own, dbg_starve_cnt
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_addr, dm_we, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  dbg_resp_own, dbg_starve_cnt
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles in which fetch asked for the port and lost.
// limit_hit tells the arbiter to hand the next contested cycle to fetch.
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int W     = STARVE_W
) (
    input  logic         clk,
    input  logic         rstd,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         limit_hit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit_hit = (cnt == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one BRAM port between instruction fetch and data memory: same-cycle grant,
// DM priority with bounded fetch starvation, and one-cycle-late read data routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rstd,
    mem_port_arbiter_if.slave bus
);

    logic                if_win;
    logic                dm_win;
    logic                limit_hit;
    logic                starve_inc;
    logic                starve_clr;
    logic [STARVE_W-1:0] starve_cnt;
    logic [DATA_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [3:0]          sel_we;

    resp_own_t           resp_own;
    logic                if_rvalid_q;
    logic                dm_rvalid_q;

    // DM normally wins a contested cycle; fetch wins only once it has lost STARVE_LIMIT in a row.
    always_comb begin
        if_win     = bus.if_req & (~bus.dm_req | limit_hit);
        dm_win     = bus.dm_req & ~if_win;
        starve_inc = bus.if_req & ~if_win;
        starve_clr = ~starve_inc;
    end

    always_comb begin
        sel_addr  = bus.if_addr;
        sel_wdata = '0;
        sel_we    = MEM_WE_NONE;
        if (dm_win) begin
            sel_addr  = bus.dm_addr;
            sel_wdata = bus.dm_wdata;
            sel_we    = bus.dm_we;
        end
    end

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (STARVE_W)
    ) u_starve_counter (
        .clk       (clk),
        .rstd      (rstd),
        .inc       (starve_inc),
        .clr       (starve_clr),
        .cnt       (starve_cnt),
        .limit_hit (limit_hit)
    );

    // Response owner: remembers whose read is on the BRAM output next cycle.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            resp_own    <= NONE;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
        end else if (if_win) begin
            resp_own    <= IF;
            if_rvalid_q <= 1'b1;
            dm_rvalid_q <= 1'b0;
        end else if (dm_win && is_read(bus.dm_we)) begin
            resp_own    <= DM;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b1;
        end else begin
            resp_own    <= NONE;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
        end
    end

    assign bus.if_gnt    = if_win;
    assign bus.dm_gnt    = dm_win;

    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_we    = sel_we;

    // Both consumers see the raw BRAM output; only the one with rvalid may use it.
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;

    assign bus.dbg_resp_own   = resp_own;
    assign bus.dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (starvation limits 4 and 1) driven with the
// same directed and random traffic, each backed by a BRAM model and a reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstd = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DW)) bus4 ();
    mem_port_arbiter_if #(.DATA_W(DW)) bus1 ();

    mem_port_arbiter #(.DATA_W(DW), .STARVE_LIMIT(4)) dut4 (
        .clk  (clk),
        .rstd (rstd),
        .bus  (bus4)
    );

    mem_port_arbiter #(.DATA_W(DW), .STARVE_LIMIT(1)) dut1 (
        .clk  (clk),
        .rstd (rstd),
        .bus  (bus1)
    );

    // BRAM models: byte-enabled write, registered read of the presented address.
    logic [31:0] bram4 [256] = '{default: '0};
    logic [31:0] bram1 [256] = '{default: '0};

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus4.mem_we[b]) bram4[bus4.mem_addr[9:2]][8*b +: 8] <= bus4.mem_wdata[8*b +: 8];
            if (bus1.mem_we[b]) bram1[bus1.mem_addr[9:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
        end
        bus4.mem_rdata <= bram4[bus4.mem_addr[9:2]];
        bus1.mem_rdata <= bram1[bus1.mem_addr[9:2]];
    end

    // ---------------- scoreboard / reference model ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    int          lim [2] = '{4, 1};
    int          starve [2];
    int          pend [2];            // 0 = nothing due, 1 = fetch read due, 2 = data read due
    logic [31:0] pend_data [2];
    logic [31:0] ref_mem [2][256];
    logic        seen_if_gnt [2];

    typedef struct {
        logic        if_gnt;
        logic        dm_gnt;
        logic [3:0]  mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        if_rvalid;
        logic        dm_rvalid;
        logic [31:0] if_rdata;
        logic [31:0] dm_rdata;
        logic [3:0]  starve;
    } obs_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int k, output obs_t o);
        if (k == 0) begin
            o.if_gnt = bus4.if_gnt;       o.dm_gnt = bus4.dm_gnt;
            o.mem_we = bus4.mem_we;       o.mem_addr = bus4.mem_addr;
            o.mem_wdata = bus4.mem_wdata;
            o.if_rvalid = bus4.if_rvalid; o.dm_rvalid = bus4.dm_rvalid;
            o.if_rdata = bus4.if_rdata;   o.dm_rdata = bus4.dm_rdata;
            o.starve = bus4.dbg_starve_cnt;
        end else begin
            o.if_gnt = bus1.if_gnt;       o.dm_gnt = bus1.dm_gnt;
            o.mem_we = bus1.mem_we;       o.mem_addr = bus1.mem_addr;
            o.mem_wdata = bus1.mem_wdata;
            o.if_rvalid = bus1.if_rvalid; o.dm_rvalid = bus1.dm_rvalid;
            o.if_rdata = bus1.if_rdata;   o.dm_rdata = bus1.dm_rdata;
            o.starve = bus1.dbg_starve_cnt;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic [31:0] daddr, input logic [3:0] dwe, input logic [31:0] dwd);
        bus4.if_req = ireq; bus4.if_addr = iaddr; bus4.dm_req = dreq;
        bus4.dm_addr = daddr; bus4.dm_we = dwe; bus4.dm_wdata = dwd;
        bus1.if_req = ireq; bus1.if_addr = iaddr; bus1.dm_req = dreq;
        bus1.dm_addr = daddr; bus1.dm_we = dwe; bus1.dm_wdata = dwd;
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic [31:0] daddr, input logic [3:0] dwe, input logic [31:0] dwd);
        obs_t        o;
        logic        e_if, e_dm;
        logic [31:0] acc_addr;
        logic [7:0]  w;
        string       p;
        drive(ireq, iaddr, dreq, daddr, dwe, dwd);
        #1;
        for (int k = 0; k < 2; k++) begin
            p = $sformatf("L%0d", lim[k]);
            get_obs(k, o);
            e_if = ireq && (!dreq || (starve[k] == lim[k]));
            e_dm = dreq && !e_if;
            acc_addr = e_dm ? daddr : iaddr;
            w = acc_addr[9:2];
            seen_if_gnt[k] = o.if_gnt;
            chk({p, " if_gnt"},   32'(o.if_gnt),   32'(e_if));
            chk({p, " dm_gnt"},   32'(o.dm_gnt),   32'(e_dm));
            chk({p, " mem_we"},   32'(o.mem_we),   e_dm ? 32'(dwe) : 32'(MEM_WE_NONE));
            chk({p, " mem_addr"}, o.mem_addr,      acc_addr);
            if (e_dm) chk({p, " mem_wdata"}, o.mem_wdata, dwd);
            chk({p, " if_rvalid"}, 32'(o.if_rvalid), 32'(pend[k] == 1));
            chk({p, " dm_rvalid"}, 32'(o.dm_rvalid), 32'(pend[k] == 2));
            if (pend[k] == 1) chk({p, " if_rdata"}, o.if_rdata, pend_data[k]);
            if (pend[k] == 2) chk({p, " dm_rdata"}, o.dm_rdata, pend_data[k]);
            chk({p, " starve_cnt"}, 32'(o.starve), 32'(starve[k]));
            if (rstd) begin
                if (e_if || (e_dm && dwe == 4'b0000)) begin
                    pend[k]      = e_if ? 1 : 2;
                    pend_data[k] = ref_mem[k][w];
                end else begin
                    pend[k] = 0;
                end
                if (e_dm) begin
                    for (int b = 0; b < 4; b++)
                        if (dwe[b]) ref_mem[k][w][8*b +: 8] = dwd[8*b +: 8];
                end
                if (!ireq || e_if) starve[k] = 0;
                else if (starve[k] < lim[k]) starve[k]++;
            end else begin
                pend[k]   = 0;
                starve[k] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);
    endtask

    // Fetch granted, then reset asserted asynchronously before the edge that would
    // have captured the next fetch; the pending response must vanish.
    task automatic reset_mid_read(input logic [31:0] a);
        obs_t o;
        cycle(1'b1, a, 1'b0, 32'h0, 4'b0, 32'h0);
        drive(1'b1, a, 1'b0, 32'h0, 4'b0, 32'h0);
        #1;
        for (int k = 0; k < 2; k++) begin
            get_obs(k, o);
            chk($sformatf("L%0d rst pre if_rvalid", lim[k]), 32'(o.if_rvalid), 32'd1);
            chk($sformatf("L%0d rst pre if_gnt", lim[k]),    32'(o.if_gnt),    32'd1);
        end
        #2 rstd = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            get_obs(k, o);
            chk($sformatf("L%0d rst async if_rvalid", lim[k]), 32'(o.if_rvalid), 32'd0);
            chk($sformatf("L%0d rst async dm_rvalid", lim[k]), 32'(o.dm_rvalid), 32'd0);
            chk($sformatf("L%0d rst async starve", lim[k]),    32'(o.starve),    32'd0);
            chk($sformatf("L%0d rst gnt follows req", lim[k]), 32'(o.if_gnt),    32'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            get_obs(k, o);
            chk($sformatf("L%0d rst cyc6 if_rvalid", lim[k]), 32'(o.if_rvalid), 32'd0);
            chk($sformatf("L%0d rst cyc6 starve", lim[k]),    32'(o.starve),    32'd0);
            pend[k]   = 0;
            starve[k] = 0;
        end
        rstd = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        obs_t  o;
        string pat4;
        string pat1;
        logic  ireq, dreq;
        logic [3:0] dwe;

        for (int k = 0; k < 2; k++) begin
            starve[k] = 0; pend[k] = 0; pend_data[k] = '0; seen_if_gnt[k] = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = '0;
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0);
        rstd = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, and grants still following requests while in reset.
        for (int k = 0; k < 2; k++) begin
            get_obs(k, o);
            chk($sformatf("L%0d reset if_rvalid", lim[k]), 32'(o.if_rvalid), 32'd0);
            chk($sformatf("L%0d reset dm_rvalid", lim[k]), 32'(o.dm_rvalid), 32'd0);
            chk($sformatf("L%0d reset starve", lim[k]),    32'(o.starve),    32'd0);
        end
        cycle(1'b1, 32'h10, 1'b1, 32'h20, 4'b0, 32'h0);
        cycle(1'b1, 32'h10, 1'b0, 32'h0, 4'b0, 32'h0);
        rstd = 1'b1;
        idle(1);

        // Preload through the arbiter.
        cycle(1'b0, 32'h0, 1'b1, 32'h10,  4'hF, 32'h0051_3093);
        cycle(1'b0, 32'h0, 1'b1, 32'h100, 4'hF, 32'hFFFF_FFFF);

        // Fetch only.
        cycle(1'b1, 32'h10, 1'b0, 32'h0, 4'b0, 32'h0);
        get_obs(0, o);
        chk("if_only if_rvalid", 32'(o.if_rvalid), 32'd1);
        chk("if_only if_rdata",  o.if_rdata,       32'h0051_3093);
        chk("if_only dm_rvalid", 32'(o.dm_rvalid), 32'd0);
        idle(1);

        // Partial DM write then read-back.
        cycle(1'b0, 32'h0, 1'b1, 32'h100, 4'b0011, 32'h0000_BEEF);
        get_obs(0, o);
        chk("dm_write no rvalid", 32'(o.dm_rvalid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 32'h100, 4'b0000, 32'h0);
        get_obs(0, o);
        chk("dm_read dm_rvalid", 32'(o.dm_rvalid), 32'd1);
        chk("dm_read dm_rdata",  o.dm_rdata,       32'hFFFF_BEEF);
        idle(4);

        // Contested cycle with an empty counter.
        cycle(1'b1, 32'h10, 1'b1, 32'h100, 4'b0, 32'h0);
        get_obs(0, o);
        chk("simul starve after edge", 32'(o.starve), 32'd1);
        idle(2);

        // Continuous dual requests: bounded starvation pattern.
        pat4 = "DDDDIDDDDIDD";
        pat1 = "DIDIDIDIDIDI";
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 32'h10, 1'b1, 32'h100, 4'b0, 32'h0);
            chk($sformatf("L4 pattern %0d", i), 32'(seen_if_gnt[0]), 32'(pat4[i] == "I"));
            chk($sformatf("L1 pattern %0d", i), 32'(seen_if_gnt[1]), 32'(pat1[i] == "I"));
        end
        // Write against a fetch below the limit: write wins, fetch is counted.
        idle(1);
        cycle(1'b1, 32'h10, 1'b1, 32'h40, 4'b1010, 32'hA5A5_5A5A);
        idle(2);

        // Random traffic, including non-contiguous byte enables.
        for (int i = 0; i < 400; i++) begin
            ireq = ($urandom_range(0, 3) != 0);
            dreq = ($urandom_range(0, 2) != 0);
            dwe  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            cycle(ireq, {22'b0, 8'($urandom_range(0, 255)), 2'b00},
                  dreq, {22'b0, 8'($urandom_range(0, 255)), 2'b00}, dwe, $urandom);
        end
        idle(2);

        reset_mid_read(32'h10);
        idle(3);
        cycle(1'b1, 32'h10, 1'b0, 32'h0, 4'b0, 32'h0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single BRAM port between the instruction-fetch requester (IF) and the memory-access requester (DM). It sits between the pipeline front/back ends and the `bram` instance, grants at most one access per cycle and routes the one-cycle-late read data back to the owner. It also applies a bounded-starvation policy so that fetch always makes progress under back-to-back loads and stores.

## Interface
Parameters:
- DATA_W, 32, data and address width.
- STARVE_LIMIT, 4, consecutive denied IF cycles after which IF gets forced priority; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstd  in  1  reset; asynchronous, active-low.
- if_req  in  1  IF read request; held with if_addr until if_gnt.
- if_addr  in  DATA_W  IF byte address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- dm_req  in  1  DM request; held with dm_addr, dm_we and dm_wdata until dm_gnt.
- dm_addr  in  DATA_W  DM byte address.
- dm_we  in  4  byte write enables; 0 means read.
- dm_wdata  in  DATA_W  pre-shifted write data.
- dm_gnt  out  1  DM request accepted this cycle.
- dm_rvalid  out  1  dm_rdata valid; reads only.
- dm_rdata  out  DATA_W  raw loaded word.
- mem_addr  out  DATA_W  to BRAM address.
- mem_we  out  4  to BRAM byte write enables.
- mem_wdata  out  DATA_W  to BRAM write data.
- mem_rdata  in  DATA_W  from BRAM; valid the cycle after the address.

## Operation
- Grant decision is combinational in the cycle of the request.
  - Only one requester active: that requester is granted.
  - Both active: DM wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- starve_cnt (4 bits):
  - Increments when if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
  - Clears when if_gnt=1 or when if_req=0.
- mem_addr/mem_wdata come from the granted requester. When nothing is granted, they come from IF.
- mem_we = dm_we when dm_gnt=1, else 0. IF never writes.
- Response tracking register resp_own, with states NONE, IF, DM:
  - Next state is IF on if_gnt; DM on dm_gnt with dm_we==0; otherwise NONE.
  - A granted DM write produces no rvalid.
- Response outputs:
  - if_rvalid = (resp_own==IF); dm_rvalid = (resp_own==DM).
  - Both rdata outputs carry mem_rdata directly.
  - When an rvalid is low, the matching rdata is undefined to consumers; the bench must not check it.
- No request queueing. A non-granted requester keeps its request asserted; the arbiter stores nothing of it.
- dm_we with a non-contiguous pattern is passed through unchanged. Legality is memory_ctl's responsibility.

## Timing
- Grant latency: 0 cycles (same cycle as req). Read data latency: 1 cycle after grant.
- Throughput: one access per cycle. Back-to-back grants to alternating owners are legal. Each rvalid corresponds to exactly the grant one cycle earlier.
- Reset values: resp_own=NONE, starve_cnt=0, if_rvalid=0, dm_rvalid=0.
  - gnt outputs follow req combinationally even during reset. Requesters ignore grants while rstd=0.
- Reset asserted mid-operation: any pending response is dropped, so no rvalid appears in the cycle after reset release. Counter restarts at 0.
- Simultaneous requests with starve_cnt at the limit: IF is granted and the counter clears the same edge. DM is granted next cycle if still requesting.
- DM write and IF request together, below the limit: write granted. IF is denied and counted.
- STARVE_LIMIT=1: fetch and DM alternate under continuous dual requests.

## Structure
- Shared package (`mem_arb_pkg`):
  - typedef enum resp_own_t {NONE, IF, DM}.
  - Constant MEM_WE_NONE = 4'b0000.
  - Default STARVE_LIMIT.
- One natural sub-module, `starve_counter`: a saturating counter with inc/clr/limit-hit ports. Everything else stays in the top module.

## Test plan
- IF only:
  - Stimulus: if_req=1, if_addr=0x0000_0010; BRAM word there = 0x0051_3093.
  - Required: if_gnt same cycle, then if_rvalid=1 with if_rdata=0x0051_3093 next cycle; dm_rvalid stays 0.
- DM write then read:
  - Stimulus: dm_we=4'b0011, dm_addr=0x100, dm_wdata=0x0000_BEEF; next cycle read 0x100; BRAM previously held 0xFFFF_FFFF.
  - Required: write cycle drives mem_we=0011 with no rvalid; read returns dm_rdata=0xFFFF_BEEF.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: continuous if_req and dm_req for 12 cycles.
  - Required: grant pattern DDDDI DDDDI DD; if_rvalid one cycle after each I grant.
- Simultaneous, below limit:
  - Stimulus: both requests in one cycle with starve_cnt=0.
  - Required: dm_gnt=1, if_gnt=0, starve_cnt=1 after the edge.
- Reset mid-read:
  - Stimulus: IF granted at cycle 5; rstd=0 asynchronously before the cycle-6 edge.
  - Required: if_rvalid=0 in cycle 6; counter is 0 after release.
- Idle:
  - Stimulus: no requests for 3 cycles.
  - Required: mem_we=0 and both rvalid=0 throughout.
